// File: rtl/axi3_rd_arbiter_if.sv
// rtl/axi3_rd_arbiter_if.sv - upstream and downstream AXI3 read signals of the read arbiter
interface axi3_rd_arbiter_if #(
   parameter int N_PORTS    = 3,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 4,
   parameter int IDX_W      = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) ();
   logic [N_PORTS-1:0]            s_arvalid;
   logic [N_PORTS-1:0]            s_arready;
   logic [N_PORTS*ADDR_WIDTH-1:0] s_araddr;
   logic [N_PORTS*ID_WIDTH-1:0]   s_arid;
   logic [N_PORTS*4-1:0]          s_arlen;
   logic [N_PORTS*3-1:0]          s_arsize;
   logic [N_PORTS*2-1:0]          s_arburst;
   logic [N_PORTS-1:0]            s_rvalid;
   logic [N_PORTS-1:0]            s_rready;
   logic [DATA_WIDTH-1:0]         s_rdata;
   logic [ID_WIDTH-1:0]           s_rid;
   logic [1:0]                    s_rresp;
   logic                          s_rlast;

   logic                          m_arvalid;
   logic                          m_arready;
   logic [ADDR_WIDTH-1:0]         m_araddr;
   logic [IDX_W+ID_WIDTH-1:0]     m_arid;
   logic [3:0]                    m_arlen;
   logic [2:0]                    m_arsize;
   logic [1:0]                    m_arburst;
   logic                          m_rvalid;
   logic                          m_rready;
   logic [DATA_WIDTH-1:0]         m_rdata;
   logic [IDX_W+ID_WIDTH-1:0]     m_rid;
   logic [1:0]                    m_rresp;
   logic                          m_rlast;

   modport master (
      input  s_arvalid, s_araddr, s_arid, s_arlen, s_arsize, s_arburst, s_rready,
      output s_arready, s_rvalid, s_rdata, s_rid, s_rresp, s_rlast,
      output m_arvalid, m_araddr, m_arid, m_arlen, m_arsize, m_arburst, m_rready,
      input  m_arready, m_rvalid, m_rdata, m_rid, m_rresp, m_rlast
   );

   modport slave (
      output s_arvalid, s_araddr, s_arid, s_arlen, s_arsize, s_arburst, s_rready,
      input  s_arready, s_rvalid, s_rdata, s_rid, s_rresp, s_rlast,
      input  m_arvalid, m_araddr, m_arid, m_arlen, m_arsize, m_arburst, m_rready,
      output m_arready, m_rvalid, m_rdata, m_rid, m_rresp, m_rlast
   );
endinterface

// File: rtl/axi3_rd_arbiter.sv
// rtl/axi3_rd_arbiter.sv - round-robin AXI3 read arbiter with ID tagging and per-port burst limits
module axi3_rd_arbiter #(
   parameter int N_PORTS         = 3,
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int ID_WIDTH        = 4,
   parameter int MAX_OUTSTANDING = 4,
   parameter int IDX_W           = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   axi3_rd_arbiter_if.master     bus,
   output logic                  err_bad_rid
);
   logic [N_PORTS-1:0][3:0]      r_cnt;
   logic [IDX_W-1:0]             r_rr_ptr;
   logic                         r_arvalid;
   logic [ADDR_WIDTH-1:0]        r_araddr;
   logic [IDX_W+ID_WIDTH-1:0]    r_arid;
   logic [3:0]                   r_arlen;
   logic [2:0]                   r_arsize;
   logic [1:0]                   r_arburst;
   logic                         r_err_bad_rid;

   logic [N_PORTS-1:0]           w_eligible;
   logic                         w_load;
   logic                         w_grant_valid;
   logic                         w_grant;
   logic [IDX_W-1:0]             w_grant_idx;
   logic [N_PORTS-1:0]           w_arready;
   logic [N_PORTS-1:0]           w_dec;
   logic [IDX_W-1:0]             w_ridx;
   logic                         w_r_ok;
   logic [N_PORTS-1:0]           w_rvalid;

   always_comb begin
      for (int i = 0; i < N_PORTS; i++) begin
         w_eligible[i] = bus.s_arvalid[i] && (r_cnt[i] < 4'(MAX_OUTSTANDING));
      end
   end

   // Walk downward so the last match written is the one closest to r_rr_ptr.
   always_comb begin
      int p;
      p             = 0;
      w_grant_valid = 1'b0;
      w_grant_idx   = '0;
      for (int k = N_PORTS - 1; k >= 0; k--) begin
         p = int'(r_rr_ptr) + k;
         if (p >= N_PORTS) p = p - N_PORTS;
         if (w_eligible[p]) begin
            w_grant_valid = 1'b1;
            w_grant_idx   = p[IDX_W-1:0];
         end
      end
   end

   assign w_load  = !r_arvalid || bus.m_arready;
   assign w_grant = w_load && w_grant_valid;

   always_comb begin
      w_arready = '0;
      if (w_grant) w_arready[w_grant_idx] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_arvalid <= 1'b0;
         r_araddr  <= '0;
         r_arid    <= '0;
         r_arlen   <= '0;
         r_arsize  <= '0;
         r_arburst <= '0;
         r_rr_ptr  <= '0;
      end else if (w_load) begin
         r_arvalid <= w_grant_valid;
         if (w_grant_valid) begin
            r_araddr  <= bus.s_araddr[w_grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
            r_arid    <= {w_grant_idx, bus.s_arid[w_grant_idx*ID_WIDTH +: ID_WIDTH]};
            r_arlen   <= bus.s_arlen[w_grant_idx*4 +: 4];
            r_arsize  <= bus.s_arsize[w_grant_idx*3 +: 3];
            r_arburst <= bus.s_arburst[w_grant_idx*2 +: 2];
            r_rr_ptr  <= (w_grant_idx == IDX_W'(N_PORTS - 1)) ? '0 : w_grant_idx + 1'b1;
         end
      end
   end

   assign w_ridx = bus.m_rid[IDX_W+ID_WIDTH-1:ID_WIDTH];
   assign w_r_ok = (32'(w_ridx) < $unsigned(N_PORTS));

   always_comb begin
      w_rvalid = '0;
      if (w_r_ok) w_rvalid[w_ridx] = bus.m_rvalid;
   end

   // Beats with an out-of-range index are sunk so the downstream channel never stalls.
   assign bus.m_rready = w_r_ok ? bus.s_rready[w_ridx] : 1'b1;

   always_comb begin
      w_dec = '0;
      if (w_r_ok && bus.m_rvalid && bus.m_rready && bus.m_rlast) w_dec[w_ridx] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else begin
         for (int i = 0; i < N_PORTS; i++) begin
            if (w_arready[i] && !w_dec[i]) begin
               r_cnt[i] <= r_cnt[i] + 4'd1;
            end else if (w_dec[i] && !w_arready[i] && (r_cnt[i] != 4'd0)) begin
               r_cnt[i] <= r_cnt[i] - 4'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_err_bad_rid <= 1'b0;
      end else if (bus.m_rvalid && !w_r_ok) begin
         r_err_bad_rid <= 1'b1;
      end
   end

   assign bus.s_arready = w_arready;
   assign bus.s_rvalid  = w_rvalid;
   assign bus.s_rdata   = bus.m_rdata;
   assign bus.s_rid     = bus.m_rid[ID_WIDTH-1:0];
   assign bus.s_rresp   = bus.m_rresp;
   assign bus.s_rlast   = bus.m_rlast;
   assign bus.m_arvalid = r_arvalid;
   assign bus.m_araddr  = r_araddr;
   assign bus.m_arid    = r_arid;
   assign bus.m_arlen   = r_arlen;
   assign bus.m_arsize  = r_arsize;
   assign bus.m_arburst = r_arburst;
   assign err_bad_rid   = r_err_bad_rid;
endmodule

// File: tb/tb_axi3_rd_arbiter.sv
// tb/tb_axi3_rd_arbiter.sv - directed self-checking bench for axi3_rd_arbiter
module tb_axi3_rd_arbiter;
   logic clk;
   logic rst;
   logic err_bad_rid;
   int   n_checks;
   int   n_errors;

   axi3_rd_arbiter_if #(.N_PORTS(3), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) bus ();

   axi3_rd_arbiter #(
      .N_PORTS(3), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .MAX_OUTSTANDING(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus),
      .err_bad_rid(err_bad_rid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clear_inputs();
      bus.s_arvalid = '0;
      bus.s_araddr  = '0;
      bus.s_arid    = '0;
      bus.s_arlen   = '0;
      bus.s_arsize  = '0;
      bus.s_arburst = '0;
      bus.s_rready  = '0;
      bus.m_arready = 1'b0;
      bus.m_rvalid  = 1'b0;
      bus.m_rdata   = '0;
      bus.m_rid     = '0;
      bus.m_rresp   = '0;
      bus.m_rlast   = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      clear_inputs();
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_addrs();
      for (int i = 0; i < 3; i++) begin
         bus.s_araddr[i*32 +: 32] = 32'h100 * (i + 1);
         bus.s_arid[i*4 +: 4]     = 4'(i + 5);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      clear_inputs();
      #1;
      n_checks++;
      if (bus.m_arvalid !== 1'b0 || bus.m_araddr !== 32'h0 || bus.m_arid !== 6'h0) begin
         n_errors++;
         $display("FAIL reset_ar: arvalid=%b addr=%h id=%h required 0/0/0", bus.m_arvalid, bus.m_araddr, bus.m_arid);
      end
      n_checks++;
      if (dut.r_cnt !== 12'h000 || dut.r_rr_ptr !== 2'd0 || err_bad_rid !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_state: cnt=%h rr=%0d err=%b required 000/0/0", dut.r_cnt, dut.r_rr_ptr, err_bad_rid);
      end
      n_checks++;
      if (bus.s_arready !== 3'b000 || bus.s_rvalid !== 3'b000) begin
         n_errors++;
         $display("FAIL reset_ready: arready=%b rvalid=%b required 000/000", bus.s_arready, bus.s_rvalid);
      end
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_single_port();
      do_reset();
      bus.s_arvalid          = 3'b010;
      bus.s_araddr[32 +: 32] = 32'h1000;
      bus.s_arid[4 +: 4]     = 4'd3;
      bus.s_arlen[4 +: 4]    = 4'd7;
      bus.s_arsize[3 +: 3]   = 3'd2;
      bus.s_arburst[2 +: 2]  = 2'd1;
      #1;
      n_checks++;
      if (bus.s_arready !== 3'b010) begin
         n_errors++;
         $display("FAIL single_grant: arready=%b required 010", bus.s_arready);
      end
      next_cycle();
      bus.s_arvalid = 3'b000;
      #1;
      n_checks++;
      if (bus.m_arvalid !== 1'b1 || bus.m_araddr !== 32'h1000 || bus.m_arid !== 6'h13 ||
          bus.m_arlen !== 4'd7 || bus.m_arsize !== 3'd2 || bus.m_arburst !== 2'd1) begin
         n_errors++;
         $display("FAIL single_ar: v=%b addr=%h id=%h len=%0d size=%0d burst=%0d required 1/1000/13/7/2/1",
                  bus.m_arvalid, bus.m_araddr, bus.m_arid, bus.m_arlen, bus.m_arsize, bus.m_arburst);
      end
      n_checks++;
      if (dut.r_cnt[1] !== 4'd1) begin
         n_errors++;
         $display("FAIL single_cnt_inc: cnt1=%0d required 1", dut.r_cnt[1]);
      end
      bus.m_arready = 1'b1;
      next_cycle();
      bus.m_arready = 1'b0;
      bus.s_rready  = 3'b111;
      for (int b = 0; b < 8; b++) begin
         bus.m_rvalid = 1'b1;
         bus.m_rid    = 6'h13;
         bus.m_rdata  = 32'hA0 + 32'(b);
         bus.m_rlast  = (b == 7);
         #1;
         n_checks++;
         if (bus.s_rvalid !== 3'b010 || bus.s_rdata !== 32'hA0 + 32'(b) || bus.s_rid !== 4'd3 || bus.m_rready !== 1'b1) begin
            n_errors++;
            $display("FAIL single_rbeat%0d: rvalid=%b data=%h rid=%h rready=%b required 010/%h/3/1",
                     b, bus.s_rvalid, bus.s_rdata, bus.s_rid, bus.m_rready, 32'hA0 + 32'(b));
         end
         if (b == 7) begin
            n_checks++;
            if (dut.r_cnt[1] !== 4'd1) begin
               n_errors++;
               $display("FAIL single_cnt_before_last: cnt1=%0d required 1", dut.r_cnt[1]);
            end
         end
         next_cycle();
      end
      bus.m_rvalid = 1'b0;
      bus.m_rlast  = 1'b0;
      #1;
      n_checks++;
      if (dut.r_cnt[1] !== 4'd0 || bus.m_arvalid !== 1'b0) begin
         n_errors++;
         $display("FAIL single_cnt_dec: cnt1=%0d arvalid=%b required 0/0", dut.r_cnt[1], bus.m_arvalid);
      end
      bus.m_rvalid = 1'b1;
      bus.s_rready = 3'b101;
      #1;
      n_checks++;
      if (bus.m_rready !== 1'b0) begin
         n_errors++;
         $display("FAIL single_rready_bp: m_rready=%b required 0", bus.m_rready);
      end
      bus.m_rvalid = 1'b0;
   endtask

   task automatic test_round_robin();
      logic [2:0] exp_rdy;
      do_reset();
      set_addrs();
      bus.s_arvalid = 3'b111;
      bus.m_arready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         exp_rdy = 3'b001 << (k % 3);
         #1;
         n_checks++;
         if (bus.s_arready !== exp_rdy) begin
            n_errors++;
            $display("FAIL rr_grant%0d: arready=%b required %b", k, bus.s_arready, exp_rdy);
         end
         if (k > 0) begin
            n_checks++;
            if (bus.m_arid !== {2'((k - 1) % 3), 4'(((k - 1) % 3) + 5)}) begin
               n_errors++;
               $display("FAIL rr_arid%0d: m_arid=%h required port %0d", k, bus.m_arid, (k - 1) % 3);
            end
         end
         next_cycle();
      end
      #1;
      n_checks++;
      if (bus.s_arready !== 3'b000 || dut.r_cnt !== {4'd2, 4'd2, 4'd2}) begin
         n_errors++;
         $display("FAIL rr_all_limited: arready=%b cnt=%h required 000/222", bus.s_arready, dut.r_cnt);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      set_addrs();
      bus.s_arvalid = 3'b111;
      bus.m_arready = 1'b1;
      #1;
      n_checks++;
      if (bus.s_arready !== 3'b001) begin
         n_errors++;
         $display("FAIL bp_first_grant: arready=%b required 001", bus.s_arready);
      end
      next_cycle();
      bus.m_arready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         n_checks++;
         if (bus.s_arready !== 3'b000 || bus.m_arvalid !== 1'b1 || bus.m_araddr !== 32'h100 || bus.m_arid !== 6'h05) begin
            n_errors++;
            $display("FAIL bp_hold%0d: arready=%b v=%b addr=%h id=%h required 000/1/100/05",
                     k, bus.s_arready, bus.m_arvalid, bus.m_araddr, bus.m_arid);
         end
         next_cycle();
      end
      bus.m_arready = 1'b1;
      #1;
      n_checks++;
      if (bus.s_arready !== 3'b010) begin
         n_errors++;
         $display("FAIL bp_resume_grant: arready=%b required 010", bus.s_arready);
      end
      next_cycle();
      #1;
      n_checks++;
      if (bus.m_araddr !== 32'h200 || bus.m_arid !== 6'h16) begin
         n_errors++;
         $display("FAIL bp_resume_ar: addr=%h id=%h required 200/16", bus.m_araddr, bus.m_arid);
      end
   endtask

   task automatic test_limit();
      do_reset();
      set_addrs();
      bus.s_arvalid = 3'b001;
      bus.m_arready = 1'b1;
      next_cycle();
      next_cycle();
      bus.s_arvalid = 3'b101;
      #1;
      n_checks++;
      if (bus.s_arready !== 3'b100 || dut.r_cnt[0] !== 4'd2) begin
         n_errors++;
         $display("FAIL limit_mask: arready=%b cnt0=%0d required 100/2", bus.s_arready, dut.r_cnt[0]);
      end
      next_cycle();
      bus.s_arvalid = 3'b001;
      bus.s_rready  = 3'b001;
      bus.m_rvalid  = 1'b1;
      bus.m_rlast   = 1'b1;
      bus.m_rid     = 6'h05;
      #1;
      n_checks++;
      if (bus.s_arready !== 3'b000) begin
         n_errors++;
         $display("FAIL limit_still_masked: arready=%b required 000", bus.s_arready);
      end
      next_cycle();
      bus.m_rvalid = 1'b0;
      bus.m_rlast  = 1'b0;
      #1;
      n_checks++;
      if (bus.s_arready !== 3'b001 || dut.r_cnt[0] !== 4'd1) begin
         n_errors++;
         $display("FAIL limit_regrant: arready=%b cnt0=%0d required 001/1", bus.s_arready, dut.r_cnt[0]);
      end
   endtask

   task automatic test_simultaneous_bad_id();
      do_reset();
      set_addrs();
      bus.s_arvalid = 3'b010;
      bus.m_arready = 1'b1;
      bus.s_rready  = 3'b111;
      next_cycle();
      bus.m_rvalid = 1'b1;
      bus.m_rlast  = 1'b1;
      bus.m_rid    = 6'h10;
      #1;
      n_checks++;
      if (bus.s_arready !== 3'b010 || bus.s_rvalid !== 3'b010 || dut.r_cnt[1] !== 4'd1) begin
         n_errors++;
         $display("FAIL simul_setup: arready=%b rvalid=%b cnt1=%0d required 010/010/1",
                  bus.s_arready, bus.s_rvalid, dut.r_cnt[1]);
      end
      next_cycle();
      bus.s_arvalid = 3'b000;
      bus.m_rvalid  = 1'b0;
      bus.m_rlast   = 1'b0;
      #1;
      n_checks++;
      if (dut.r_cnt[1] !== 4'd1) begin
         n_errors++;
         $display("FAIL simul_cnt: cnt1=%0d required 1", dut.r_cnt[1]);
      end
      bus.s_rready = 3'b000;
      bus.m_rvalid = 1'b1;
      bus.m_rlast  = 1'b1;
      bus.m_rid    = 6'h30;
      #1;
      n_checks++;
      if (bus.m_rready !== 1'b1 || bus.s_rvalid !== 3'b000 || err_bad_rid !== 1'b0) begin
         n_errors++;
         $display("FAIL badid_comb: rready=%b rvalid=%b err=%b required 1/000/0", bus.m_rready, bus.s_rvalid, err_bad_rid);
      end
      next_cycle();
      bus.m_rvalid = 1'b0;
      bus.m_rlast  = 1'b0;
      next_cycle();
      next_cycle();
      #1;
      n_checks++;
      if (err_bad_rid !== 1'b1 || dut.r_cnt !== {4'd0, 4'd1, 4'd0}) begin
         n_errors++;
         $display("FAIL badid_sticky: err=%b cnt=%h required 1/010", err_bad_rid, dut.r_cnt);
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      set_addrs();
      bus.s_arvalid = 3'b111;
      bus.m_arready = 1'b1;
      next_cycle();
      next_cycle();
      bus.m_arready = 1'b0;
      bus.s_rready  = 3'b111;
      bus.m_rvalid  = 1'b1;
      bus.m_rid     = 6'h05;
      #2;
      rst = 1'b0;
      #1;
      n_checks++;
      if (bus.m_arvalid !== 1'b0 || dut.r_cnt !== 12'h000 || dut.r_rr_ptr !== 2'd0) begin
         n_errors++;
         $display("FAIL midrst_async: arvalid=%b cnt=%h rr=%0d required 0/000/0", bus.m_arvalid, dut.r_cnt, dut.r_rr_ptr);
      end
      @(negedge clk);
      rst = 1'b1;
      bus.m_arready = 1'b1;
      bus.m_rlast   = 1'b1;
      bus.m_rid     = 6'h16;
      #1;
      n_checks++;
      if (bus.s_arready !== 3'b001 || bus.s_rvalid !== 3'b010) begin
         n_errors++;
         $display("FAIL midrst_first_grant: arready=%b rvalid=%b required 001/010", bus.s_arready, bus.s_rvalid);
      end
      next_cycle();
      bus.s_arvalid = 3'b000;
      bus.m_rvalid  = 1'b0;
      bus.m_rlast   = 1'b0;
      #1;
      n_checks++;
      if (dut.r_cnt !== {4'd0, 4'd0, 4'd1} || bus.m_arid !== 6'h05) begin
         n_errors++;
         $display("FAIL midrst_after: cnt=%h arid=%h required 001/05", dut.r_cnt, bus.m_arid);
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst      = 1'b0;
      clear_inputs();
      @(negedge clk);
      test_reset();
      test_single_port();
      test_round_robin();
      test_backpressure();
      test_limit();
      test_simultaneous_bad_id();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
